// File: rtl/adpll_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adpll_pkg
// Brief    : Shared ADPLL types: PFD state encoding and signed error clamp.
// Revision : 1.0 - initial release
// ============================================================================
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } pfd_state_t;

  localparam int unsigned ERROR_WIDTH_DEF = 8;

  // Largest magnitude of a symmetric signed code; the most negative code is excluded.
  function automatic int unsigned err_clamp(input int unsigned width);
    return (32'd1 << (width - 32'd1)) - 32'd1;
  endfunction

  localparam int unsigned ERROR_CLAMP_DEF = err_clamp(ERROR_WIDTH_DEF);

endpackage
`default_nettype wire

// File: rtl/pfd_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : pfd_edge_sync
// Brief    : Optional 2-flop synchronizer (COUNTER_PFD_SYNC_EN) plus rise detect.
// Revision : 1.0 - initial release
// ============================================================================
module pfd_edge_sync (
  input  logic gen_clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic rise_o
);

  logic w_sampled;
  logic r_prev;

`ifdef COUNTER_PFD_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], sig_i};
    end
  end

  assign w_sampled = r_sync[1];
`else
  assign w_sampled = sig_i;
`endif

  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_sampled;
    end
  end

  assign rise_o = w_sampled & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/counter_pfd.sv
`default_nettype none
// ============================================================================
// Module   : counter_pfd
// Brief    : Counter-based PFD emitting one signed, saturated error pulse per
//            ref/fb edge pair. Build option: COUNTER_PFD_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module counter_pfd
  import adpll_pkg::*;
#(
  parameter int ERROR_WIDTH = ERROR_WIDTH_DEF
) (
  input  logic                          gen_clk_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic                          ref_i,
  input  logic                          fb_i,
  output logic signed [ERROR_WIDTH-1:0] error_o,
  output logic                          error_valid_o,
  output logic                          sat_o
);

  localparam int CW = ERROR_WIDTH - 1;
  localparam logic [CW-1:0] c_cnt_max = CW'(err_clamp(ERROR_WIDTH));
  localparam logic [CW-1:0] c_cnt_one = CW'(1);

  logic w_ref_rise;
  logic w_fb_rise;
  logic signed [ERROR_WIDTH-1:0] w_pos;
  logic signed [ERROR_WIDTH-1:0] w_neg;

  pfd_state_t                    r_state;
  logic [CW-1:0]                 r_cnt;
  logic                          r_ovf;
  logic signed [ERROR_WIDTH-1:0] r_error;
  logic                          r_valid;
  logic                          r_sat;

  pfd_edge_sync u_ref_sync (
    .gen_clk_i (gen_clk_i),
    .reset_i   (reset_i),
    .sig_i     (ref_i),
    .rise_o    (w_ref_rise)
  );

  pfd_edge_sync u_fb_sync (
    .gen_clk_i (gen_clk_i),
    .reset_i   (reset_i),
    .sig_i     (fb_i),
    .rise_o    (w_fb_rise)
  );

  assign w_pos = {1'b0, r_cnt};
  assign w_neg = -w_pos;

  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_error <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_error <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
      if (!enable_i) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_ref_rise && w_fb_rise) begin
              r_valid <= 1'b1;
            end else if (w_ref_rise) begin
              r_state <= REF_LEAD;
              r_cnt   <= c_cnt_one;
              r_ovf   <= 1'b0;
            end else if (w_fb_rise) begin
              r_state <= FB_LEAD;
              r_cnt   <= c_cnt_one;
              r_ovf   <= 1'b0;
            end
          end
          REF_LEAD: begin
            if (w_fb_rise) begin
              r_error <= w_pos;
              r_valid <= 1'b1;
              r_sat   <= r_ovf;
              r_ovf   <= 1'b0;
              // A coincident ref edge opens the next measurement immediately.
              if (w_ref_rise) begin
                r_cnt <= c_cnt_one;
              end else begin
                r_state <= IDLE;
                r_cnt   <= '0;
              end
            end else if (r_cnt == c_cnt_max) begin
              r_ovf <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end
          FB_LEAD: begin
            if (w_ref_rise) begin
              r_error <= w_neg;
              r_valid <= 1'b1;
              r_sat   <= r_ovf;
              r_ovf   <= 1'b0;
              if (w_fb_rise) begin
                r_cnt <= c_cnt_one;
              end else begin
                r_state <= IDLE;
                r_cnt   <= '0;
              end
            end else if (r_cnt == c_cnt_max) begin
              r_ovf <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign error_o       = r_error;
  assign error_valid_o = r_valid;
  assign sat_o         = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_counter_pfd.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_pfd
// Brief    : Directed self-checking bench for counter_pfd (either build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_pfd;

`ifdef COUNTER_PFD_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic              gen_clk_i = 1'b0;
  logic              reset_i;
  logic              enable_i;
  logic              ref_i;
  logic              fb_i;
  logic signed [7:0] error_o;
  logic              error_valid_o;
  logic              sat_o;

  typedef struct {
    int cyc;
    int err;
    int sat;
  } pulse_t;

  pulse_t q[$];
  pulse_t mon_p;
  int     cyc   = 0;
  int     n_chk = 0;
  int     n_err = 0;

  counter_pfd #(.ERROR_WIDTH(8)) dut (
    .gen_clk_i     (gen_clk_i),
    .reset_i       (reset_i),
    .enable_i      (enable_i),
    .ref_i         (ref_i),
    .fb_i          (fb_i),
    .error_o       (error_o),
    .error_valid_o (error_valid_o),
    .sat_o         (sat_o)
  );

  always #5 gen_clk_i = ~gen_clk_i;

  always @(posedge gen_clk_i) cyc <= cyc + 1;

  // Every valid cycle is logged, so a pulse wider than one cycle shows up as an extra entry.
  always @(negedge gen_clk_i) begin
    if (error_valid_o) begin
      mon_p.cyc = cyc;
      mon_p.err = int'(error_o);
      mon_p.sat = int'(sat_o);
      q.push_back(mon_p);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge gen_clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pulse(input string tag, input int idx, input int err,
                           input int sat, input int at);
    if (idx < q.size()) begin
      chk({tag, ".err"}, q[idx].err, err);
      chk({tag, ".sat"}, q[idx].sat, sat);
      chk({tag, ".cycle"}, q[idx].cyc, at);
    end else begin
      chk({tag, ".present"}, q.size(), idx + 1);
    end
  endtask

  // Leading input rises, the other follows k cycles later; expect one pulse.
  task automatic measure(input string tag, input bit ref_first, input int k,
                         input int exp_err, input int exp_sat);
    int c2;
    q.delete();
    if (ref_first) ref_i = 1'b1; else fb_i = 1'b1;
    tick(k);
    c2 = cyc;
    if (ref_first) fb_i = 1'b1; else ref_i = 1'b1;
    tick(2);
    ref_i = 1'b0;
    fb_i  = 1'b0;
    tick(6 + LAT);
    chk({tag, ".count"}, q.size(), 1);
    chk_pulse(tag, 0, exp_err, exp_sat, c2 + 1 + LAT);
  endtask

  initial begin
    int c2;
    int c3;
    reset_i  = 1'b1;
    enable_i = 1'b1;
    ref_i    = 1'b0;
    fb_i     = 1'b0;
    tick(3);
    chk("rst.err", int'(error_o), 0);
    chk("rst.valid", int'(error_valid_o), 0);
    chk("rst.sat", int'(sat_o), 0);

    reset_i = 1'b0;
    tick(4);
    chk("idle.err", int'(error_o), 0);
    chk("idle.valid", int'(error_valid_o), 0);
    chk("idle.sat", int'(sat_o), 0);
    chk("idle.pulses", q.size(), 0);

    measure("aligned", 1'b1, 0, 0, 0);
    measure("ref5", 1'b1, 5, 5, 0);
    measure("fb12", 1'b0, 12, -12, 0);
    measure("ref127", 1'b1, 127, 127, 0);

    // fb lags by 200 with a second ref edge at +100 that must not restart the count.
    q.delete();
    ref_i = 1'b1;
    tick(60);
    ref_i = 1'b0;
    tick(40);
    ref_i = 1'b1;
    tick(100);
    c2   = cyc;
    fb_i = 1'b1;
    tick(2);
    ref_i = 1'b0;
    fb_i  = 1'b0;
    tick(6 + LAT);
    chk("sat200.count", q.size(), 1);
    chk_pulse("sat200", 0, 127, 1, c2 + 1 + LAT);

    // ref and fb rise together at cnt=7, then fb again 3 cycles later.
    q.delete();
    ref_i = 1'b1;
    tick(3);
    ref_i = 1'b0;
    tick(4);
    c2    = cyc;
    ref_i = 1'b1;
    fb_i  = 1'b1;
    tick(1);
    fb_i = 1'b0;
    tick(1);
    ref_i = 1'b0;
    tick(1);
    c3   = cyc;
    fb_i = 1'b1;
    tick(2);
    fb_i = 1'b0;
    tick(6 + LAT);
    chk("simul.count", q.size(), 2);
    chk_pulse("simul.first", 0, 7, 0, c2 + 1 + LAT);
    chk_pulse("simul.second", 1, 3, 0, c3 + 1 + LAT);

    // Asynchronous reset mid-measurement; a later fb edge must not close the old count.
    q.delete();
    ref_i = 1'b1;
    tick(40);
    #2;
    reset_i = 1'b1;
    #1;
    chk("arst.valid", int'(error_valid_o), 0);
    chk("arst.err", int'(error_o), 0);
    ref_i = 1'b0;
    tick(1);
    #2;
    reset_i = 1'b0;
    tick(3);
    fb_i = 1'b1;
    tick(4);
    fb_i = 1'b0;
    tick(6 + LAT);
    chk("arst.pulses", q.size(), 0);

    // Enable dropped at cnt=9, edges arrive while disabled, re-enable with inputs high.
    enable_i = 1'b0;
    tick(3);
    enable_i = 1'b1;
    tick(2);
    q.delete();
    ref_i = 1'b1;
    tick(9);
    enable_i = 1'b0;
    tick(2);
    fb_i = 1'b1;
    tick(4);
    enable_i = 1'b1;
    tick(8 + LAT);
    chk("en.pulses", q.size(), 0);
    ref_i = 1'b0;
    fb_i  = 1'b0;
    tick(4);
    measure("en.fb3", 1'b0, 3, -3, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
